// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiplier: M-extension op codes and the
// sequencer states, plus helpers deciding which operands are signed.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic a_is_signed(op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic b_is_signed(op_e op);
    return (op == OP_MULH);
  endfunction

endpackage

// File: rtl/mul_if.sv
// Request/response bundle between the EX stage and the multiplier sequencer.
interface mul_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/mul_dp.sv
// Multiplier datapath: operand magnitude capture, radix-2 shift-add
// accumulation over a 2*XLEN product register, final sign fix and half select.
module mul_dp
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  op_e             i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0] r_prod;
  logic              r_neg;
  logic              r_lo_sel;
  logic [XLEN-1:0]   r_result;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_shifted;
  logic [2*XLEN-1:0] w_fixed;

  always_comb begin
    w_a_neg = a_is_signed(i_op) & i_a[XLEN-1];
    w_b_neg = b_is_signed(i_op) & i_b[XLEN-1];
    // Negating the most negative value wraps back to itself, which is the
    // correct unsigned magnitude.
    w_a_mag = w_a_neg ? -i_a : i_a;
    w_b_mag = w_b_neg ? -i_b : i_b;
    // Multiplier sits in the low half and is consumed LSB-first as the
    // partial sum shifts in from the top, carry included.
    w_sum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    w_shifted = {w_sum, r_prod[XLEN-1:1]};
    w_fixed   = r_neg ? -r_prod : r_prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_lo_sel <= 1'b0;
      r_result <= '0;
    end else if (i_load) begin
      r_mcand  <= w_a_mag;
      r_prod   <= {{XLEN{1'b0}}, w_b_mag};
      r_neg    <= w_a_neg ^ w_b_neg;
      r_lo_sel <= (i_op == OP_MUL);
    end else if (i_step) begin
      r_prod <= w_shifted;
    end else if (i_fix) begin
      r_prod   <= w_fixed;
      r_result <= r_lo_sel ? w_fixed[XLEN-1:0] : w_fixed[2*XLEN-1:XLEN];
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle multiply sequencer for the EX stage: owns the FSM, iteration
// counter and pipeline stall/done handshake; arithmetic lives in mul_dp.
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst_n,
  mul_if.slave bus
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic w_load;
  logic w_step;
  logic w_fix;

  assign w_load = (r_state == IDLE) && bus.start && !bus.flush;
  assign w_step = (r_state == RUN)  && !bus.flush;
  assign w_fix  = (r_state == SIGN) && !bus.flush;

  // Stall drops in DONE so EX advances and captures the result that cycle.
  assign bus.stall = w_load || (r_state == RUN) || (r_state == SIGN);
  assign bus.busy  = (r_state != IDLE);
  assign bus.done  = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= SIGN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SIGN: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  mul_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_fix    (w_fix),
    .i_op     (op_e'(bus.op)),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_result (bus.result)
  );

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver pushes expected results, and an
// independent monitor pops and compares them on each done pulse.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_if #(.XLEN(32)) bus ();

  mul_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          start_edge;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          edge_cnt = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: widen to signed 66 bits per operand signedness and multiply.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0]  ea;
    logic signed [65:0]  eb;
    logic signed [131:0] p;
    logic                sa;
    logic                sb_;
    sa  = (op == 2'b01) || (op == 2'b10);
    sb_ = (op == 2'b01);
    ea  = {{34{sa & a[31]}}, a};
    eb  = {{34{sb_ & b[31]}}, b};
    p   = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn result=0x%08h expect=0x%08h latency=%0d", bus.result, e.res,
                 edge_cnt - e.start_edge + 1);
        check("result", bus.result, e.res);
        check("latency", edge_cnt - e.start_edge + 1, 34);
        check("stall_in_done", bus.stall, 0);
        last_res = e.res;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [32:0] fixed_exp);
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 1, 0);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    if (push) begin
      e.res        = fixed_exp[32] ? fixed_exp[31:0] : ref_mul(op, a, b);
      e.start_edge = edge_cnt + 1;
      sb.push_back(e);
    end
    #1 check("stall_on_start", bus.stall, 1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  logic [31:0] corners [5];

  initial begin
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF;
    corners[4] = 32'h7FFF_FFFF;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_result", bus.result, 0);
    check("reset_stall", bus.stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7*6 with stall window checks
    issue(2'b00, 32'd7, 32'd6, 1'b1, {1'b1, 32'h0000_002A});
    check("busy_run", bus.busy, 1);
    repeat (31) @(negedge clk);
    check("stall_last_run", bus.stall, 1);
    @(negedge clk);
    check("stall_sign", bus.stall, 1);
    check("no_early_done", bus.done, 0);
    drain();

    // Directed signedness cases, issued back-to-back
    issue(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b1, {1'b1, 32'hFFFF_FFFF});
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, {1'b1, 32'h4000_0000});
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'hFFFF_FFFE});
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'h0000_0001});
    issue(2'b10, 32'hFFFF_FFFF, 32'd2, 1'b1, {1'b1, 32'hFFFF_FFFF});
    issue(2'b10, 32'd2, 32'hFFFF_FFFF, 1'b1, {1'b1, 32'h0000_0001});
    issue(2'b00, 32'd1234, 32'd0, 1'b1, {1'b1, 32'h0000_0000});
    drain();

    // Flush during RUN: no done, result keeps previous value
    issue(2'b00, 32'h1234, 32'h5678, 1'b0, '0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_run_idle", bus.busy, 0);
    check("flush_run_result", bus.result, last_res);
    repeat (40) @(negedge clk);
    check("flush_run_result_hold", bus.result, last_res);

    // Flush during SIGN
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b0, '0);
    repeat (32) @(negedge clk);
    check("sign_stall", bus.stall, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_sign_idle", bus.busy, 0);
    check("flush_sign_done", bus.done, 0);
    check("flush_sign_result", bus.result, last_res);

    // start held high through RUN is ignored
    issue(2'b11, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, '0);
    bus.start = 1'b1;
    bus.a     = 32'h1111_1111;
    bus.b     = 32'h2222_2222;
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // flush + start together in IDLE
    bus.start = 1'b1;
    bus.flush = 1'b1;
    #1 check("flush_start_stall", bus.stall, 0);
    @(negedge clk);
    check("flush_start_busy", bus.busy, 0);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);

    // Flush during DONE: pulse still delivered
    issue(2'b00, 32'd100, 32'd200, 1'b1, {1'b1, 32'd20000});
    repeat (33) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_done_idle", bus.busy, 0);
    check("flush_done_result", bus.result, 32'd20000);

    // Async reset mid-operation
    issue(2'b00, 32'h11, 32'h22, 1'b1, '0);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_result", bus.result, 0);
    check("arst_stall", bus.stall, 0);
    sb.delete();
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd5, 1'b1, {1'b1, 32'd15});
    drain();

    // Randomized back-to-back ops against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      issue(op, a, b, 1'b1, '0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
